// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;
  localparam int DEF_AF_LEVEL = 14;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // The count needs one extra bit so that a completely full FIFO (== depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port and one synchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered flags and status pulses.
// Define SYNC_FIFO_COUNT_EN to expose the occupancy as data_count.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] data_count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              wr_ok, rd_ok;
  logic              dout_clr;
  logic [DATA_W-1:0] mem_q;

  // Request semantics: wr_en/rd_en are sampled at each rising edge against the
  // pre-edge full/empty flags; an accepted request gets a one-cycle *_ack, a
  // refused one a one-cycle *_err. No request is ever held or retried.
  assign wr_ok = wr_en & ~full & clear_n;
  assign rd_ok = rd_en & ~empty & clear_n;

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)      count_nxt = count + 1'b1;
    else if (rd_ok && !wr_ok) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_err       <= 1'b0;
      dout_clr     <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      wr_ack       <= wr_ok;
      wr_err       <= wr_en & full;
      rd_ack       <= rd_ok;
      rd_err       <= rd_en & empty;
      if (rd_ok) dout_clr <= 1'b0;
    end
  end

  // The storage has no reset, so a reset-time zero is forced until the first accepted read.
  assign dout = dout_clr ? '0 : mem_q;

`ifdef SYNC_FIFO_COUNT_EN
  assign data_count = count;
`endif

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based model.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AE     = 2;
  localparam int AF     = 14;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clear_n = 1'b0;
  logic              wr_en = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic full, almost_full, empty, almost_empty;
  logic wr_ack, wr_err, rd_ack, rd_err;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0] data_count;
`endif

  sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AE_LEVEL (AE),
    .AF_LEVEL (AF)
  ) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .data_count   (data_count)
`endif
  );

  // scoreboard: the FIFO contents as a plain queue
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ".dout"},         32'(dout),         32'(exp_dout));
    check({tag, ".empty"},        32'(empty),        32'(sz == 0));
    check({tag, ".full"},         32'(full),         32'(sz == DEPTH));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
    check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
    check({tag, ".wr_ack"},       32'(wr_ack),       32'(exp_wr_ack));
    check({tag, ".wr_err"},       32'(wr_err),       32'(exp_wr_err));
    check({tag, ".rd_ack"},       32'(rd_ack),       32'(exp_rd_ack));
    check({tag, ".rd_err"},       32'(rd_err),       32'(exp_rd_err));
`ifdef SYNC_FIFO_COUNT_EN
    check({tag, ".data_count"},   32'(data_count),   32'(sz));
`endif
  endtask

  // driver: apply one cycle of requests, advance the model, compare after the edge
  task automatic step(input string tag, input logic c, input logic w, input logic r,
                      input logic [DATA_W-1:0] d);
    int  sz;
    logic wr_ok, rd_ok;
    @(negedge clk);
    clear_n = c; wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    if (!c) begin
      exp_q.delete();
      exp_dout = '0;
      exp_wr_ack = 0; exp_wr_err = 0; exp_rd_ack = 0; exp_rd_err = 0;
    end else begin
      sz = exp_q.size();
      wr_ok = w && (sz < DEPTH);
      rd_ok = r && (sz > 0);
      exp_wr_ack = wr_ok;
      exp_wr_err = w && !wr_ok;
      exp_rd_ack = rd_ok;
      exp_rd_err = r && !rd_ok;
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // reset held for two cycles
    step("reset0", 0, 1, 1, 8'hAA);
    step("reset1", 0, 0, 0, 8'h00);

    // fill 0x00..0x0F, then one write too many
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 1, 0, 8'(i));
    step("overfill", 1, 1, 0, 8'h5A);
    check("overfill.size", 32'(exp_q.size()), 32'(DEPTH));

    // drain in order, then one read too many (dout holds 0x0F)
    for (int i = 0; i < DEPTH; i++) step("drain", 1, 0, 1, 8'h00);
    step("underflow", 1, 0, 1, 8'h00);
    check("underflow.dout", 32'(dout), 32'h0F);

    // count 8, concurrent read+write across pointer wrap
    for (int i = 0; i < 8; i++) step("half", 1, 1, 0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 20; i++) step("both8", 1, 1, 1, 8'($urandom_range(0, 255)));
    check("both8.size", 32'(exp_q.size()), 32'd8);

    // full with both requests: read wins, write rejected
    for (int i = 0; i < 8; i++) step("topup", 1, 1, 0, 8'($urandom_range(0, 255)));
    step("full_both", 1, 1, 1, 8'hC3);
    check("full_both.size", 32'(exp_q.size()), 32'(DEPTH - 1));

    // empty with both requests: write wins, read rejected
    for (int i = 0; i < DEPTH - 1; i++) step("empty_out", 1, 0, 1, 8'h00);
    step("empty_both", 1, 1, 1, 8'h3C);
    check("empty_both.size", 32'(exp_q.size()), 32'd1);

    // reset at count 5, then a read must be refused
    for (int i = 0; i < 4; i++) step("five", 1, 1, 0, 8'($urandom_range(0, 255)));
    step("mid_reset", 0, 1, 1, 8'h77);
    step("post_reset_rd", 1, 0, 1, 8'h00);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
